// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared widths, constants and arithmetic helpers for the Sobel stage
package sobel_pkg;

   localparam int SOBEL_PIX_W   = 8;
   localparam int SOBEL_SUM_W   = 10;
   localparam int SOBEL_MAG_W   = 11;
   localparam int SOBEL_LATENCY = 3;

   localparam logic [SOBEL_PIX_W-1:0] SOBEL_SAT = 8'd255;

   typedef logic [SOBEL_PIX_W-1:0] pix_t;
   typedef logic [SOBEL_SUM_W-1:0] sum_t;
   typedef logic [SOBEL_MAG_W-1:0] mag_t;

   // Weighted 1-2-1 column/row sum of three taps; max 4*255 = 1020 fits in 10 bits.
   function automatic sum_t sobel_taps(input pix_t a, input pix_t m, input pix_t b);
      return sum_t'(a) + (sum_t'(m) << 1) + sum_t'(b);
   endfunction

   // Clamp the 11-bit magnitude sum into an 8-bit pixel.
   function automatic pix_t sobel_saturate(input mag_t s);
      return (s > mag_t'(SOBEL_SAT)) ? SOBEL_SAT : s[SOBEL_PIX_W-1:0];
   endfunction

endpackage

// File: rtl/sobel_gradient_if.sv
// rtl/sobel_gradient_if.sv - window-in / edge-pixel-out bundle for sobel_gradient
interface sobel_gradient_if;
   import sobel_pkg::*;

   pix_t d0_i;
   pix_t d1_i;
   pix_t d2_i;
   pix_t d3_i;
   pix_t d4_i;
   pix_t d5_i;
   pix_t d6_i;
   pix_t d7_i;
   pix_t d8_i;
   logic done_i;
   logic sof_i;

   pix_t edge_o;
   logic done_o;
   logic frame_done_o;

   // Window producer side (data buffer / testbench).
   modport master (
      output d0_i, d1_i, d2_i, d3_i, d4_i, d5_i, d6_i, d7_i, d8_i,
      output done_i, sof_i,
      input  edge_o, done_o, frame_done_o
   );

   // Gradient engine side.
   modport slave (
      input  d0_i, d1_i, d2_i, d3_i, d4_i, d5_i, d6_i, d7_i, d8_i,
      input  done_i, sof_i,
      output edge_o, done_o, frame_done_o
   );

endinterface

// File: rtl/sobel_grad_axis.sv
// rtl/sobel_grad_axis.sv - one Sobel axis: weighted tap sums (S1) then absolute difference (S2)
module sobel_grad_axis
   import sobel_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic s1_en,
   input  logic s2_en,
   input  pix_t pa,
   input  pix_t pm,
   input  pix_t pb,
   input  pix_t na,
   input  pix_t nm,
   input  pix_t nb,
   output sum_t mag
);

   sum_t p_sum;
   sum_t n_sum;
   sum_t abs_diff;

   // S1: register positive and negative weighted sums; hold when no window arrives.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p_sum <= '0;
         n_sum <= '0;
      end else if (s1_en) begin
         p_sum <= sobel_taps(pa, pm, pb);
         n_sum <= sobel_taps(na, nm, nb);
      end
   end

   // Magnitude of the signed difference, formed by ordering the operands so no sign bit is needed.
   always_comb begin
      abs_diff = '0;
      if (p_sum >= n_sum) abs_diff = p_sum - n_sum;
      else                abs_diff = n_sum - p_sum;
   end

   // S2: register the axis gradient magnitude.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)       mag <= '0;
      else if (s2_en) mag <= abs_diff;
   end

endmodule

// File: rtl/sobel_gradient.sv
// rtl/sobel_gradient.sv - Sobel |Gx|+|Gy| edge stage, 3-cycle pipeline; SOBEL_THRESHOLD_EN selects 0/255 binarised output
module sobel_gradient
   import sobel_pkg::*;
#(
   parameter int IMG_W     = 640,
   parameter int IMG_H     = 480,
   parameter int THRESHOLD = 128
)
(
   input  logic            clk,
   input  logic            rst,
   sobel_gradient_if.slave bus
);

   localparam int CW = $clog2(IMG_W) + 1;
   localparam int RW = $clog2(IMG_H) + 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   logic [CW-1:0] col_cnt, col_nxt, cap_col;
   logic [RW-1:0] row_cnt, row_nxt, cap_row;
   logic          cap_border;
   logic          cap_last;

   logic v1, v2;
   logic b1, b2;
   logic l1, l2;

   sum_t ax, ay;
   mag_t s_sum;
   pix_t s_val;

   pix_t edge_q;
   logic done_q;
   logic fd_q;

   // Position of the incoming window and the counter update; sof forces this window to (0,0).
   always_comb begin
      cap_col = bus.sof_i ? '0 : col_cnt;
      cap_row = bus.sof_i ? '0 : row_cnt;
      col_nxt = col_cnt;
      row_nxt = row_cnt;
      if (bus.done_i) begin
         if (cap_col == COL_LAST) begin
            col_nxt = '0;
            row_nxt = (cap_row == ROW_LAST) ? '0 : cap_row + 1'b1;
         end else begin
            col_nxt = cap_col + 1'b1;
            row_nxt = cap_row;
         end
      end else if (bus.sof_i) begin
         col_nxt = '0;
         row_nxt = '0;
      end
      cap_border = (cap_col < CW'(2)) || (cap_row < RW'(2));
      cap_last   = (cap_col == COL_LAST) && (cap_row == ROW_LAST);
   end

   // Column/row position counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_cnt <= '0;
         row_cnt <= '0;
      end else begin
         col_cnt <= col_nxt;
         row_cnt <= row_nxt;
      end
   end

   // Valid pipeline plus border/last-pixel flags travelling alongside the data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         b1 <= 1'b0;
         b2 <= 1'b0;
         l1 <= 1'b0;
         l2 <= 1'b0;
      end else begin
         v1 <= bus.done_i;
         v2 <= v1;
         if (bus.done_i) begin
            b1 <= cap_border;
            l1 <= cap_last;
         end
         if (v1) begin
            b2 <= b1;
            l2 <= l1;
         end
      end
   end

   // Horizontal gradient: right column minus left column.
   sobel_grad_axis u_axis_x (
      .clk   (clk),
      .rst   (rst),
      .s1_en (bus.done_i),
      .s2_en (v1),
      .pa    (bus.d2_i),
      .pm    (bus.d5_i),
      .pb    (bus.d8_i),
      .na    (bus.d0_i),
      .nm    (bus.d3_i),
      .nb    (bus.d6_i),
      .mag   (ax)
   );

   // Vertical gradient: bottom row minus top row.
   sobel_grad_axis u_axis_y (
      .clk   (clk),
      .rst   (rst),
      .s1_en (bus.done_i),
      .s2_en (v1),
      .pa    (bus.d6_i),
      .pm    (bus.d7_i),
      .pb    (bus.d8_i),
      .na    (bus.d0_i),
      .nm    (bus.d1_i),
      .nb    (bus.d2_i),
      .mag   (ay)
   );

   // S3 value: summed magnitude, either saturated or binarised.
   always_comb begin
      s_sum = mag_t'(ax) + mag_t'(ay);
`ifdef SOBEL_THRESHOLD_EN
      s_val = (s_sum >= mag_t'(THRESHOLD)) ? SOBEL_SAT : 8'd0;
`else
      s_val = sobel_saturate(s_sum);
`endif
   end

`ifndef SOBEL_THRESHOLD_EN
   logic unused_threshold;
   assign unused_threshold = ^THRESHOLD;
`endif

   // The centre tap carries no weight in either Sobel kernel.
   logic unused_centre;
   assign unused_centre = ^bus.d4_i;

   // S3 output register; edge holds its last value between strobes, border pixels forced to 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         edge_q <= '0;
         done_q <= 1'b0;
         fd_q   <= 1'b0;
      end else begin
         done_q <= v2;
         fd_q   <= v2 & l2;
         if (v2) edge_q <= b2 ? 8'd0 : s_val;
      end
   end

   assign bus.edge_o       = edge_q;
   assign bus.done_o       = done_q;
   assign bus.frame_done_o = fd_q;

endmodule

// File: tb/tb_sobel_gradient.sv
// tb/tb_sobel_gradient.sv - self-checking bench for sobel_gradient with a behavioural edge model
module tb_sobel_gradient;

   localparam int W = 4;
   localparam int H = 4;
   localparam int T = 128;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   sobel_gradient_if bus ();

   sobel_gradient #(.IMG_W(W), .IMG_H(H), .THRESHOLD(T)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int         due;
      logic [7:0] edge_v;
      logic       fd;
   } exp_t;

   exp_t       q[$];
   int         checks   = 0;
   int         failures = 0;
   int         pc       = 0;
   int         m_col    = 0;
   int         m_row    = 0;
   logic [7:0] last_edge = 8'd0;
   bit         mon_en   = 1'b0;

   // posedge counter used as the time base for expected arrivals
   always @(posedge clk) pc <= pc + 1;

   function automatic logic [7:0] ref_edge(input int w[9], input int c, input int r);
      int gx, gy, s;
      gx = (w[2] + 2 * w[5] + w[8]) - (w[0] + 2 * w[3] + w[6]);
      gy = (w[6] + 2 * w[7] + w[8]) - (w[0] + 2 * w[1] + w[2]);
      s  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      if (c < 2 || r < 2) return 8'd0;
`ifdef SOBEL_THRESHOLD_EN
      return (s >= T) ? 8'd255 : 8'd0;
`else
      return (s > 255) ? 8'd255 : 8'(s);
`endif
   endfunction

   // one clock of stimulus; records the expected output of a strobed window
   task automatic feed(input bit strobe, input bit sof, input int w[9], output int due);
      int c, r;
      exp_t e;
      @(negedge clk);
      bus.d0_i = 8'(w[0]); bus.d1_i = 8'(w[1]); bus.d2_i = 8'(w[2]);
      bus.d3_i = 8'(w[3]); bus.d4_i = 8'(w[4]); bus.d5_i = 8'(w[5]);
      bus.d6_i = 8'(w[6]); bus.d7_i = 8'(w[7]); bus.d8_i = 8'(w[8]);
      bus.done_i = strobe;
      bus.sof_i  = sof;
      due = pc + 3;
      if (strobe) begin
         c = sof ? 0 : m_col;
         r = sof ? 0 : m_row;
         e.due    = due;
         e.edge_v = ref_edge(w, c, r);
         e.fd     = (c == W - 1) && (r == H - 1);
         q.push_back(e);
         m_col = (c + 1) % W;
         m_row = (c == W - 1) ? (r + 1) % H : r;
      end else if (sof) begin
         m_col = 0;
         m_row = 0;
      end
   endtask

   task automatic rand_win(output int w[9]);
      for (int k = 0; k < 9; k++) w[k] = int'($urandom_range(0, 255));
   endtask

   task automatic feed_idle();
      int w[9];
      int d;
      rand_win(w);
      feed(1'b0, 1'b0, w, d);
   endtask

   // cycle-by-cycle scoreboard on the output side
   always @(negedge clk) begin
      if (rst && mon_en) begin
         while (q.size() > 0 && q[0].due < pc) begin
            checks++; failures++;
            $display("FAIL mon_missed due=%0d now=%0d got=none required=done_o", q[0].due, pc);
            void'(q.pop_front());
         end
         if (q.size() > 0 && q[0].due == pc) begin
            checks++;
            if (bus.done_o !== 1'b1 || bus.edge_o !== q[0].edge_v || bus.frame_done_o !== q[0].fd) begin
               failures++;
               $display("FAIL mon_pixel t=%0d got done=%b edge=%0d fd=%b required done=1 edge=%0d fd=%b",
                        pc, bus.done_o, bus.edge_o, bus.frame_done_o, q[0].edge_v, q[0].fd);
            end
            last_edge = q[0].edge_v;
            void'(q.pop_front());
         end else begin
            checks++;
            if (bus.done_o !== 1'b0 || bus.frame_done_o !== 1'b0 || bus.edge_o !== last_edge) begin
               failures++;
               $display("FAIL mon_idle t=%0d got done=%b fd=%b edge=%0d required done=0 fd=0 edge=%0d",
                        pc, bus.done_o, bus.frame_done_o, bus.edge_o, last_edge);
            end
         end
      end
   end

   task automatic drain();
      for (int k = 0; k < 8 && q.size() > 0; k++) feed_idle();
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain got=%0d pending required=0", q.size());
         q.delete();
      end
   endtask

   task automatic wait_due(input int due);
      for (int k = 0; k < 8 && pc < due; k++) feed_idle();
   endtask

   task automatic test_reset();
      int w[9];
      rst = 1'b0;
      mon_en = 1'b0;
      bus.done_i = 1'b0;
      bus.sof_i  = 1'b0;
      rand_win(w);
      bus.d0_i = 8'(w[0]); bus.d1_i = 8'(w[1]); bus.d2_i = 8'(w[2]);
      bus.d3_i = 8'(w[3]); bus.d4_i = 8'(w[4]); bus.d5_i = 8'(w[5]);
      bus.d6_i = 8'(w[6]); bus.d7_i = 8'(w[7]); bus.d8_i = 8'(w[8]);
      repeat (3) @(negedge clk);
      checks++;
      if (bus.done_o !== 1'b0) begin failures++; $display("FAIL reset_done got=%b required=0", bus.done_o); end
      checks++;
      if (bus.edge_o !== 8'd0) begin failures++; $display("FAIL reset_edge got=%0d required=0", bus.edge_o); end
      checks++;
      if (bus.frame_done_o !== 1'b0) begin failures++; $display("FAIL reset_fd got=%b required=0", bus.frame_done_o); end
      q.delete();
      last_edge = 8'd0;
      m_col = 0;
      m_row = 0;
      rst = 1'b1;
      mon_en = 1'b1;
   endtask

   // sof window at (0,0) plus nine fillers: the next strobe lands at row 2, col 2
   task automatic goto_interior();
      int w[9];
      int d;
      rand_win(w);
      feed(1'b1, 1'b1, w, d);
      for (int k = 0; k < 9; k++) begin
         rand_win(w);
         feed(1'b1, 1'b0, w, d);
      end
   endtask

   task automatic directed(input string name, input int w[9], input logic [7:0] required);
      int due;
      goto_interior();
      feed(1'b1, 1'b0, w, due);
      wait_due(due);
      checks++;
      if (pc != due || bus.done_o !== 1'b1 || bus.edge_o !== required) begin
         failures++;
         $display("FAIL %s got done=%b edge=%0d t=%0d required done=1 edge=%0d t=%0d",
                  name, bus.done_o, bus.edge_o, pc, required, due);
      end
   endtask

   task automatic test_flat();
      int w[9];
      w = '{100, 100, 100, 100, 100, 100, 100, 100, 100};
      directed("flat", w, 8'd0);
   endtask

   task automatic test_vertical();
      int w[9];
      w = '{0, 0, 255, 0, 0, 255, 0, 0, 255};
      directed("vertical_255", w, 8'd255);
      w = '{0, 0, 10, 0, 0, 10, 0, 0, 10};
`ifdef SOBEL_THRESHOLD_EN
      directed("vertical_10", w, 8'd0);
`else
      directed("vertical_10", w, 8'd40);
`endif
   endtask

   task automatic test_diagonal();
      int w[9];
      w = '{0, 50, 50, 50, 50, 50, 50, 50, 50};
`ifdef SOBEL_THRESHOLD_EN
      directed("diagonal", w, 8'd0);
`else
      directed("diagonal", w, 8'd100);
`endif
   endtask

   task automatic test_border();
      int w[9];
      int d, ndone, n255, nfd, fd_at;
      w = '{0, 0, 255, 0, 0, 255, 0, 0, 255};
      drain();
      ndone = 0; n255 = 0; nfd = 0; fd_at = 0;
      for (int i = 0; i < 19; i++) begin
         if (i < 16) feed(1'b1, i == 0, w, d);
         else        feed_idle();
         if (bus.done_o === 1'b1) begin
            ndone++;
            if (bus.edge_o === 8'd255) n255++;
         end
         if (bus.frame_done_o === 1'b1) begin
            nfd++;
            fd_at = ndone;
         end
      end
      checks++;
      if (ndone != 16) begin failures++; $display("FAIL border_count got=%0d required=16", ndone); end
      checks++;
      if (n255 != 4) begin failures++; $display("FAIL border_interior got=%0d required=4", n255); end
      checks++;
      if (nfd != 1 || fd_at != 16) begin
         failures++;
         $display("FAIL border_frame_done got=%0d pulses at=%0d required=1 pulse at=16", nfd, fd_at);
      end
   endtask

   task automatic test_gapped();
      int w[9];
      int d;
      bit hist[42];
      logic req;
      w = '{0, 0, 255, 0, 0, 255, 0, 0, 255};
      drain();
      for (int i = 0; i < 42; i++) begin
         hist[i] = (i % 3 == 0) && (i < 36);
         if (hist[i]) feed(1'b1, i == 0, w, d);
         else         feed_idle();
         req = (i >= 3) ? hist[i-3] : 1'b0;
         checks++;
         if (bus.done_o !== req) begin
            failures++;
            $display("FAIL gapped_pattern i=%0d got=%b required=%b", i, bus.done_o, req);
         end
      end
   endtask

   task automatic test_random();
      int w[9];
      int d;
      drain();
      for (int i = 0; i < 300; i++) begin
         rand_win(w);
         feed($urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0, w, d);
      end
   endtask

   task automatic test_reset_inflight();
      int w[9];
      int d, due;
      w = '{0, 0, 255, 0, 0, 255, 0, 0, 255};
      drain();
      feed(1'b1, 1'b0, w, d);
      feed(1'b1, 1'b0, w, d);
      @(negedge clk);
      bus.done_i = 1'b0;
      bus.sof_i  = 1'b0;
      rst = 1'b0;
      q.delete();
      last_edge = 8'd0;
      m_col = 0;
      m_row = 0;
      @(negedge clk);
      rst = 1'b1;
      checks++;
      if (bus.done_o !== 1'b0 || bus.edge_o !== 8'd0) begin
         failures++;
         $display("FAIL rst_inflight_clear got done=%b edge=%0d required done=0 edge=0", bus.done_o, bus.edge_o);
      end
      feed(1'b1, 1'b1, w, due);
      wait_due(due);
      checks++;
      if (pc != due || bus.done_o !== 1'b1 || bus.edge_o !== 8'd0) begin
         failures++;
         $display("FAIL rst_restart got done=%b edge=%0d required done=1 edge=0", bus.done_o, bus.edge_o);
      end
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_flat();
      test_vertical();
      test_diagonal();
      test_border();
      test_gapped();
      test_random();
      test_reset_inflight();
      drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
